// File: rtl/jk_register_bank.sv
// Bank of WIDTH storage bits with runtime JK/D/T/SR mode, per-bit change flags and a sticky SR error flag.
// Latency: one register stage from sampled inputs to Q/Changed/Error; no backpressure, the bank accepts every edge.
module jk_register_bank #(
  parameter int                 WIDTH       = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             ClrErr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] Changed,
  output logic             Error
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_t;

  mode_t            mode;
  logic [WIDTH-1:0] q_next;
  logic             err_set;

  assign mode = mode_t'(Mode);

  always_comb begin
    q_next  = Q;
    err_set = 1'b0;
    if (En) begin
      case (mode)
        MODE_JK: q_next = (J & ~Q) | (~K & Q);
        MODE_D:  q_next = J;
        MODE_T:  q_next = J ^ Q;
        MODE_SR: begin
          // S=R=1 holds the bit rather than picking a winner
          q_next  = (J & ~K) | (Q & (~K | J));
          err_set = |(J & K);
        end
        default: q_next = Q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Q       <= RESET_VALUE;
      Changed <= '0;
      Error   <= 1'b0;
    end else begin
      Q       <= q_next;
      Changed <= q_next ^ Q;
      if (err_set)
        Error <= 1'b1;
      else if (ClrErr)
        Error <= 1'b0;
    end
  end

  assign Qn = ~Q;

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed bench for jk_register_bank: WIDTH=4, RESET_VALUE=4'b0101, 10 ns clock.
module tb_jk_register_bank;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       En;
  logic [1:0] Mode;
  logic [3:0] J;
  logic [3:0] K;
  logic       ClrErr;
  logic [3:0] Q;
  logic [3:0] Qn;
  logic [3:0] Changed;
  logic       Error;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  jk_register_bank #(
    .WIDTH       (4),
    .RESET_VALUE (4'b0101)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .En      (En),
    .Mode    (Mode),
    .J       (J),
    .K       (K),
    .ClrErr  (ClrErr),
    .Q       (Q),
    .Qn      (Qn),
    .Changed (Changed),
    .Error   (Error)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] q_exp, input logic [3:0] ch_exp,
                           input logic err_exp);
    check({tag, ".Q"}, Q, q_exp);
    check({tag, ".Qn"}, Qn, ~q_exp);
    check({tag, ".Changed"}, Changed, ch_exp);
    check({tag, ".Error"}, {3'b000, Error}, {3'b000, err_exp});
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b0; En = 1'b1; Mode = 2'b00; J = 4'hF; K = 4'hF; ClrErr = 1'b0;

    tick(); tick();
    check_all("reset_hold", 4'b0101, 4'b0000, 1'b0);

    @(negedge Clk);
    Reset = 1'b1; J = 4'b0000; K = 4'b0000;

    // JK truth table
    tick(); check_all("jk_hold", 4'b0101, 4'b0000, 1'b0);
    J = 4'b1100; K = 4'b0011;
    tick(); check_all("jk_set_reset", 4'b1100, 4'b1001, 1'b0);
    J = 4'b1111; K = 4'b1111;
    tick(); check_all("jk_toggle", 4'b0011, 4'b1111, 1'b0);

    // D then T
    Mode = 2'b01; J = 4'b1010; K = 4'b1111;
    tick(); check_all("d_load", 4'b1010, 4'b1001, 1'b0);
    Mode = 2'b10; J = 4'b0110;
    tick(); check_all("t_toggle1", 4'b1100, 4'b0110, 1'b0);
    tick(); check_all("t_toggle2", 4'b1010, 4'b0110, 1'b0);

    // SR from 1010: bit0 S only -> set, bit1 S=R=1 -> hold, error
    Mode = 2'b11; J = 4'b0011; K = 4'b0010;
    tick(); check_all("sr_illegal", 4'b1011, 4'b0001, 1'b1);
    J = 4'b0000; K = 4'b0000; ClrErr = 1'b0;
    tick(); check_all("sr_err_sticky", 4'b1011, 4'b0000, 1'b1);
    ClrErr = 1'b1;
    tick(); check_all("sr_err_clear", 4'b1011, 4'b0000, 1'b0);
    J = 4'b0001; K = 4'b0001;
    tick(); check_all("sr_set_wins", 4'b1011, 4'b0000, 1'b1);

    // Enable low: hold, no error set or clear with ClrErr=0
    ClrErr = 1'b0; En = 1'b0; Mode = 2'b00; J = 4'hF; K = 4'hF;
    tick(); check_all("en_hold1", 4'b1011, 4'b0000, 1'b1);
    tick(); check_all("en_hold2", 4'b1011, 4'b0000, 1'b1);
    tick(); check_all("en_hold3", 4'b1011, 4'b0000, 1'b1);
    En = 1'b1;
    tick(); check_all("en_toggle", 4'b0100, 4'b1111, 1'b1);

    // Mid-cycle asynchronous reset
    #3;
    Reset = 1'b0;
    #1;
    check_all("reset_async", 4'b0101, 4'b0000, 1'b0);
    tick(); check_all("reset_over_edge", 4'b0101, 4'b0000, 1'b0);

    // First functional edge after release
    @(negedge Clk);
    Reset = 1'b1; Mode = 2'b10; J = 4'b1111; K = 4'b0000;
    tick(); check_all("post_reset_toggle", 4'b1010, 4'b1111, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
